// File: rtl/spi_master_ctrl.sv
// SPI frame controller: sends a {cmd, wdata} frame MSB first and, for read-data
// frames, waits RD_LAT idle cycles and then captures one byte from MISO.
module spi_master_ctrl #(
    parameter int RD_LAT = 3,
    parameter int GAP    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] cmd,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       rdata_valid,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE, S_SEL, S_SHIFT, S_TAIL, S_WAIT_RD, S_CAPTURE, S_END, S_GAP
    } state_t;

    state_t     state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic [9:0] frame_sr;
    logic [1:0] cmd_q;
    logic [6:0] sreg;
    logic       in_cap;

    assign dbg_state = state;

    // Handshake: start is a level sampled only while IDLE; busy/done/rdata_valid
    // are registered and trail the state register by one cycle, like SS_n/MOSI.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            S_IDLE: if (start) state_nx = S_SEL;
            S_SEL: begin
                state_nx = S_SHIFT;
                cnt_nx   = 4'd10;
            end
            S_SHIFT: begin
                if (cnt == 4'd0) begin
                    if (cmd_q == 2'b11) begin
                        state_nx = S_WAIT_RD;
                        cnt_nx   = 4'(RD_LAT - 1);
                    end else begin
                        state_nx = S_TAIL;
                    end
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            S_TAIL: state_nx = S_END;
            S_WAIT_RD: begin
                if (cnt == 4'd0) begin
                    state_nx = S_CAPTURE;
                    cnt_nx   = 4'd7;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            S_CAPTURE: begin
                if (cnt == 4'd0) state_nx = S_END;
                else             cnt_nx   = cnt - 4'd1;
            end
            S_END: begin
                if (GAP == 1) begin
                    state_nx = S_IDLE;
                end else begin
                    state_nx = S_GAP;
                    cnt_nx   = 4'(GAP - 2);
                end
            end
            S_GAP: begin
                if (cnt == 4'd0) state_nx = S_IDLE;
                else             cnt_nx   = cnt - 4'd1;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= 4'd0;
            frame_sr    <= 10'd0;
            cmd_q       <= 2'b00;
            sreg        <= 7'd0;
            in_cap      <= 1'b0;
            SS_n        <= 1'b1;
            MOSI        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            rdata_valid <= 1'b0;
            rdata       <= 8'h00;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;

            // The first SHIFT cycle repeats frame[9] as the direction bit, so hold.
            if (state == S_IDLE && start) begin
                frame_sr <= {cmd, wdata};
                cmd_q    <= cmd;
            end else if (state == S_SHIFT && cnt != 4'd10) begin
                frame_sr <= {frame_sr[8:0], 1'b0};
            end

            SS_n        <= !(state inside {S_SEL, S_SHIFT, S_TAIL, S_WAIT_RD, S_CAPTURE});
            MOSI        <= (state == S_SHIFT) ? frame_sr[9] : 1'b0;
            busy        <= (state != S_IDLE);
            done        <= (state == S_END);
            rdata_valid <= (state == S_END) && (cmd_q == 2'b11);

            // MISO is sampled one edge after each CAPTURE cycle appears on SS_n,
            // so the eighth bit lands directly in rdata on the END edge.
            in_cap <= (state == S_CAPTURE);
            if (in_cap) sreg <= {sreg[5:0], MISO};
            if (state == S_END && cmd_q == 2'b11) rdata <= {sreg, MISO};
        end
    end

endmodule
